gpio_in_filter: RTL and testbench

Input conditioning stage between the 32 tristate GPIO pads and the ARM subsystem's gpio_0_in_i bus.
- Synchronises each pad into the system clock domain (clk_200M in the top level).
- Optionally debounces each bit with a programmable length.
- Produces per-bit rise/fall pulses and sticky edge flags for firmware polling.
- Output in_o drives gpio_0_in_i directly. Input pad_i is the raw gpio0 pad bus.

---
 rtl/gpio_in_filter.sv | 108 ++++++++++
 tb/tb_gpio_in_filter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter.sv
// gpio_in_filter
// Input conditioning between the raw GPIO pads and the SoC's GPIO input bus.
// Each bit is brought into the clk_i domain by a two-flop synchroniser. It can
// then be debounced with a shared programmable length. The block also
// produces registered rise/fall pulses and sticky edge flags for firmware
// polling.
//
// Optional feature macro: GPIO_IN_FILTER_IRQ_EN
//   When defined, adds irq_mask_i and a registered, level-sensitive irq_o
//   that is set whenever any masked edge flag is set.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   pad_i          raw pad levels (asynchronous to clk_i)
//   oe_i           per-bit SoC output enable; 1 forces bypass of the filter
//   filt_en_i      per-bit debounce enable
//   debounce_len_i debounce length N shared by all bits
//   edge_clr_i     per-bit clear for edge_flag_o
//   irq_mask_i     (IRQ build only) per-bit interrupt mask
//   in_o           conditioned level
//   rise_o         1-cycle pulse on an accepted 0->1 transition
//   fall_o         1-cycle pulse on an accepted 1->0 transition
//   edge_flag_o    sticky flag, set on any accepted transition
//   irq_o          (IRQ build only) OR of masked edge flags, registered
module gpio_in_filter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] oe_i,
  input  logic [WIDTH-1:0] filt_en_i,
  input  logic [CNT_W-1:0] debounce_len_i,
  input  logic [WIDTH-1:0] edge_clr_i,
`ifdef GPIO_IN_FILTER_IRQ_EN
  input  logic [WIDTH-1:0] irq_mask_i,
  output logic             irq_o,
`endif
  output logic [WIDTH-1:0] in_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] edge_flag_o
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] st_next;

  // Per-bit accept logic. The counter only advances while the synchronised
  // level disagrees with the accepted level. The >= compare means it is
  // never pushed past debounce_len_i, even if the length drops mid-count.
  always_comb begin
    st_next = in_o;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (!filt_en_i[i] || oe_i[i]) begin
        st_next[i] = sync2[i];
      end else if (sync2[i] != in_o[i]) begin
        if (cnt[i] >= debounce_len_i) begin
          st_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1       <= '0;
      sync2       <= '0;
      in_o        <= '0;
      rise_o      <= '0;
      fall_o      <= '0;
      edge_flag_o <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= pad_i;
      sync2  <= sync1;
      in_o   <= st_next;
      rise_o <= st_next & ~in_o;
      fall_o <= ~st_next & in_o;
      // The flag is set from the registered pulses. This puts the set one
      // cycle after the pulse, and it beats a clear in the same cycle.
      edge_flag_o <= (edge_flag_o & ~edge_clr_i) | rise_o | fall_o;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef GPIO_IN_FILTER_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |(edge_flag_o & irq_mask_i);
    end
  end
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard bench for gpio_in_filter. The stimulus process drives inputs at
// each falling edge. It then runs a behavioural model for the coming rising
// edge and queues the expected outputs. A monitor pops one entry after every
// rising edge and compares it with the outputs.
module tb_gpio_in_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pad, oe, filt_en, clr;
  logic [15:0] dlen;
  logic [31:0] mask;
  logic [31:0] in_v, rise_v, fall_v, flag_v;
`ifdef GPIO_IN_FILTER_IRQ_EN
  logic        irq_v;
`endif

  gpio_in_filter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pad_i          (pad),
    .oe_i           (oe),
    .filt_en_i      (filt_en),
    .debounce_len_i (dlen),
    .edge_clr_i     (clr),
`ifdef GPIO_IN_FILTER_IRQ_EN
    .irq_mask_i     (mask),
    .irq_o          (irq_v),
`endif
    .in_o           (in_v),
    .rise_o         (rise_v),
    .fall_o         (fall_v),
    .edge_flag_o    (flag_v)
  );

  typedef struct packed {
    logic [31:0] lvl;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] flag;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state. pad_hist holds the last two sampled pad vectors;
  // element 0 is the value that the accept logic sees. streak[i] counts the
  // consecutive filtered samples that disagree with the accepted level.
  logic [31:0] pad_hist[$];
  logic [31:0] m_lvl, m_rise, m_fall, m_flag;
  logic        m_irq;
  int          streak[32];

  task automatic model_reset();
    pad_hist = {32'h0, 32'h0};
    m_lvl = '0; m_rise = '0; m_fall = '0; m_flag = '0; m_irq = 1'b0;
    for (int i = 0; i < 32; i++) streak[i] = 0;
  endtask

  task automatic model_step();
    logic [31:0] samp, nlvl, nflag;
    logic        nirq;
    exp_t e;
    if (rst) begin
      model_reset();
    end else begin
      samp  = pad_hist[0];
      nlvl  = m_lvl;
      nflag = (m_flag & ~clr) | m_rise | m_fall;
      nirq  = |(m_flag & mask);
      for (int i = 0; i < 32; i++) begin
        if (!filt_en[i] || oe[i]) begin
          nlvl[i] = samp[i];
          streak[i] = 0;
        end else if (samp[i] == m_lvl[i]) begin
          streak[i] = 0;
        end else begin
          // A new level is accepted after N+1 consecutive disagreeing samples.
          streak[i]++;
          if (streak[i] >= int'(dlen) + 1) begin
            nlvl[i] = samp[i];
            streak[i] = 0;
          end
        end
      end
      m_rise = nlvl & ~m_lvl;
      m_fall = ~nlvl & m_lvl;
      m_lvl  = nlvl;
      m_flag = nflag;
      m_irq  = nirq;
      void'(pad_hist.pop_front());
      pad_hist.push_back(pad);
    end
    e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall; e.flag = m_flag;
    e.irq = m_irq;
    exp_q.push_back(e);
  endtask

  // Queues the expected values for the coming rising edge. It then waits for
  // the next falling edge, where the caller may change the inputs.
  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("in_o", in_v, e.lvl);
        cmp("rise_o", rise_v, e.rise);
        cmp("fall_o", fall_v, e.fall);
        cmp("edge_flag_o", flag_v, e.flag);
`ifdef GPIO_IN_FILTER_IRQ_EN
        cmp("irq_o", {31'h0, irq_v}, {31'h0, e.irq});
`endif
      end
    end
  end

  initial begin : stim
    logic [31:0] tgl;
    model_reset();
    rst = 1'b1; pad = 32'hFFFF_FFFF; oe = '0; filt_en = '0; clr = '0;
    dlen = '0; mask = '0;
    @(negedge clk);

    // Reset with all pads high, then release in bypass mode.
    cycles(3);
    rst = 1'b0;
    cycles(6);

    // Debounce step on bit 0 with N=4.
    filt_en = 32'h1; dlen = 16'd4; pad = '0;
    cycles(12);
    pad = 32'h1;
    cycles(12);

    // Glitch rejection: a 4-cycle pulse is dropped and a 5-cycle pulse passes.
    pad = '0;       cycles(12);
    pad = 32'h1;    cycles(4);
    pad = '0;       cycles(12);
    pad = 32'h1;    cycles(5);
    pad = '0;       cycles(14);

    // oe forces bypass even with a long debounce.
    filt_en = 32'h8; dlen = 16'd100; oe = 32'h8;
    for (int k = 0; k < 8; k++) begin
      pad[3] = ~pad[3];
      cycles(2 + (k % 3));
    end
    cycles(4);

    // Sticky flag: the clear coincides with the set, then a lone clear follows.
    oe = '0; filt_en = '0; dlen = '0;
    pad[5] = 1'b1; cycles(6);
    pad[5] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clr = '0;
      clr[5] = m_fall[5];
      cyc();
    end
    clr = '0;       cycles(3);
    clr = 32'h20;   cyc();
    clr = '0;       cycles(3);

    // Only bit 0 is unmasked for the interrupt.
    mask = 32'h1; clr = 32'hFFFF_FFFF; cyc();
    clr = '0;     cycles(3);
    pad[1] = ~pad[1]; cycles(6);
    pad[0] = ~pad[0]; cycles(6);
    clr = 32'h1;  cyc();
    clr = '0;     cycles(4);

    // Randomised traffic.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(99) == 0) dlen = 16'($urandom_range(6));
      if ($urandom_range(63) == 0) filt_en = $urandom();
      if ($urandom_range(63) == 0) oe = $urandom() & $urandom();
      if ($urandom_range(127) == 0) mask = $urandom();
      tgl = '0;
      for (int b = 0; b < 32; b++) tgl[b] = ($urandom_range(7) == 0);
      pad = pad ^ tgl;
      clr = $urandom() & $urandom() & $urandom();
      rst = ($urandom_range(299) == 0);
      cyc();
    end
    rst = 1'b0; clr = '0;
    cycles(4);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
